// File: rtl/dct_sequencer.sv
// Sequencer for an 8x8 2-D DCT: feeds raster pixels to the row engine, hands
// row results to the column engine, and reports block completion and protocol errors.
module dct_sequencer #(
   parameter int unsigned N       = 8,
   parameter int unsigned COL_LAT = 4
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         blk_start,
   input  logic         hold,
   output logic [5:0]   pix_addr,
   output logic         pix_rd,
   input  logic [N-1:0] pix_data,
   output logic [N-1:0] row_pix,
   output logic [2:0]   row_coef_idx,
   output logic         row_en,
   output logic         eng_clr,
   input  logic         row_done,
   output logic         col_load,
   output logic [2:0]   col_coef_idx,
   output logic         col_en,
   output logic         blk_busy,
   output logic         blk_done,
   output logic         err
);

   localparam int unsigned DW       = (COL_LAT > 1) ? $clog2(COL_LAT) : 1;
   localparam int unsigned LAST_PIX = 63;
   localparam int unsigned ROWS     = 8;

   typedef enum logic [2:0] {
      S_IDLE,
      S_CLR,
      S_FEED,
      S_WAIT_ROWS,
      S_DRAIN,
      S_DONE
   } state_t;

   state_t        state, state_nxt;
   logic [5:0]    pix_cnt, pix_cnt_nxt;
   logic [3:0]    row_cnt, row_cnt_nxt;
   logic [DW-1:0] drain_cnt, drain_cnt_nxt;
   logic [5:0]    pix_addr_nxt;
   logic [2:0]    col_coef_nxt;
   logic          pix_rd_nxt, eng_clr_nxt, col_load_nxt, col_en_nxt;
   logic          blk_busy_nxt, blk_done_nxt, err_nxt;
   logic          row_accept;
   logic          rd_q;
   logic [2:0]    addr_q;

   // State, counters and registered control outputs
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state        <= S_IDLE;
         pix_cnt      <= '0;
         row_cnt      <= '0;
         drain_cnt    <= '0;
         pix_addr     <= '0;
         pix_rd       <= 1'b0;
         eng_clr      <= 1'b0;
         col_load     <= 1'b0;
         col_coef_idx <= '0;
         col_en       <= 1'b0;
         blk_busy     <= 1'b0;
         blk_done     <= 1'b0;
         err          <= 1'b0;
      end else begin
         state        <= state_nxt;
         pix_cnt      <= pix_cnt_nxt;
         row_cnt      <= row_cnt_nxt;
         drain_cnt    <= drain_cnt_nxt;
         pix_addr     <= pix_addr_nxt;
         pix_rd       <= pix_rd_nxt;
         eng_clr      <= eng_clr_nxt;
         col_load     <= col_load_nxt;
         col_coef_idx <= col_coef_nxt;
         col_en       <= col_en_nxt;
         blk_busy     <= blk_busy_nxt;
         blk_done     <= blk_done_nxt;
         err          <= err_nxt;
      end
   end

   // Next-state and next-output decode
   always_comb begin
      state_nxt     = state;
      pix_cnt_nxt   = pix_cnt;
      row_cnt_nxt   = row_cnt;
      drain_cnt_nxt = drain_cnt;
      pix_addr_nxt  = pix_addr;
      pix_rd_nxt    = 1'b0;
      eng_clr_nxt   = 1'b0;
      col_load_nxt  = 1'b0;
      col_coef_nxt  = col_coef_idx;
      col_en_nxt    = col_en;
      blk_busy_nxt  = blk_busy;
      blk_done_nxt  = 1'b0;
      err_nxt       = err;

      // Row results are only legal while rows are outstanding; hold does not gate them
      row_accept = row_done && (state == S_FEED || state == S_WAIT_ROWS)
                   && (row_cnt < 4'(ROWS));
      if (row_accept) begin
         col_load_nxt = 1'b1;
         col_coef_nxt = row_cnt[2:0];
         row_cnt_nxt  = row_cnt + 4'd1;
         col_en_nxt   = 1'b1;
      end else if (row_done) begin
         err_nxt = 1'b1;
      end

      case (state)
         S_IDLE: begin
            if (blk_start) begin
               state_nxt    = S_CLR;
               blk_busy_nxt = 1'b1;
               eng_clr_nxt  = 1'b1;
               err_nxt      = row_done;
            end
         end
         S_CLR: begin
            pix_cnt_nxt  = '0;
            row_cnt_nxt  = '0;
            pix_addr_nxt = '0;
            state_nxt    = S_FEED;
         end
         S_FEED: begin
            if (!hold) begin
               pix_rd_nxt   = 1'b1;
               pix_addr_nxt = pix_cnt;
               if (pix_cnt == 6'(LAST_PIX)) begin
                  state_nxt = S_WAIT_ROWS;
               end else begin
                  pix_cnt_nxt = pix_cnt + 6'd1;
               end
            end
         end
         S_WAIT_ROWS: begin
            if (row_cnt == 4'(ROWS)) begin
               state_nxt     = S_DRAIN;
               drain_cnt_nxt = '0;
            end
         end
         S_DRAIN: begin
            if (drain_cnt == DW'(COL_LAT - 1)) begin
               state_nxt    = S_DONE;
               blk_done_nxt = 1'b1;
            end else begin
               drain_cnt_nxt = drain_cnt + DW'(1);
            end
         end
         S_DONE: begin
            blk_busy_nxt = 1'b0;
            col_en_nxt   = 1'b0;
            state_nxt    = S_IDLE;
         end
         default: state_nxt = S_IDLE;
      endcase
   end

   // Read-data pipeline: memory answers one cycle after pix_rd, then it is registered to the row engine
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         rd_q         <= 1'b0;
         addr_q       <= '0;
         row_en       <= 1'b0;
         row_pix      <= '0;
         row_coef_idx <= '0;
      end else begin
         rd_q   <= pix_rd;
         addr_q <= pix_addr[2:0];
         row_en <= rd_q;
         if (rd_q) begin
            row_pix      <= pix_data;
            row_coef_idx <= addr_q;
         end
      end
   end

endmodule

// File: tb/tb_dct_sequencer.sv
// Bench for dct_sequencer: pixel memory and row-engine models, a read scoreboard,
// a table of block scenarios plus hand sequences for IDLE errors and mid-block reset.
module tb_dct_sequencer;

   localparam int unsigned N       = 8;
   localparam int unsigned COL_LAT = 4;

   logic         clk = 1'b0;
   logic         reset;
   logic         blk_start;
   logic         hold;
   logic [5:0]   pix_addr;
   logic         pix_rd;
   logic [N-1:0] pix_data;
   logic [N-1:0] row_pix;
   logic [2:0]   row_coef_idx;
   logic         row_en;
   logic         eng_clr;
   logic         row_done;
   logic         col_load;
   logic [2:0]   col_coef_idx;
   logic         col_en;
   logic         blk_busy;
   logic         blk_done;
   logic         err;

   dct_sequencer #(.N(N), .COL_LAT(COL_LAT)) dut (
      .clk(clk), .reset(reset), .blk_start(blk_start), .hold(hold),
      .pix_addr(pix_addr), .pix_rd(pix_rd), .pix_data(pix_data),
      .row_pix(row_pix), .row_coef_idx(row_coef_idx), .row_en(row_en),
      .eng_clr(eng_clr), .row_done(row_done), .col_load(col_load),
      .col_coef_idx(col_coef_idx), .col_en(col_en), .blk_busy(blk_busy),
      .blk_done(blk_done), .err(err)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [N-1:0] pix;
      logic [2:0]   idx;
   } sb_t;

   typedef struct packed {
      int   hold_addr;
      int   hold_len;
      logic restart;
      logic inj;
      logic coinc;
      int   span;
      logic exp_err;
   } vec_t;

   int checks = 0;
   int errors = 0;

   logic [N-1:0] mem [64];
   sb_t          q [$];
   int           exp_addr, exp_col, loads, done_cnt, first_rd, last_rd;
   int           last_load_cyc, done_cyc, cyc;
   logic         eng_done, inj;
   logic [2:0]   re_cnt;

   task automatic chk(input string nm, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s actual=%0d expected=%0d t=%0t", nm, act, exp, $time);
      end
   endtask

   // Synchronous pixel memory
   always @(posedge clk) if (pix_rd) pix_data <= mem[pix_addr];

   // Row engine: one result per 8 row_en beats
   always @(posedge clk or posedge reset) begin
      if (reset) begin
         eng_done <= 1'b0;
         re_cnt   <= 3'd0;
      end else begin
         eng_done <= row_en && (re_cnt == 3'd7);
         if (row_en) re_cnt <= re_cnt + 3'd1;
      end
   end
   assign row_done = eng_done | inj;

   // Scoreboard and sequence monitor
   always @(negedge clk) begin
      if (!reset) begin
         if (pix_rd) begin
            chk("pix_addr_seq", int'(pix_addr), exp_addr);
            q.push_back('{pix: mem[exp_addr & 63], idx: 3'(exp_addr & 7)});
            if (first_rd < 0) first_rd = cyc;
            last_rd = cyc;
            exp_addr++;
         end
         if (row_en) begin
            if (q.size() == 0) begin
               chk("row_en_unexpected", 1, 0);
            end else begin
               sb_t e;
               e = q.pop_front();
               chk("row_pix", int'(row_pix), int'(e.pix));
               chk("row_coef_idx", int'(row_coef_idx), int'(e.idx));
            end
         end
         if (col_load) begin
            chk("col_coef_idx_seq", int'(col_coef_idx), exp_col);
            exp_col++;
            loads++;
            last_load_cyc = cyc;
         end
         if (blk_done) begin
            done_cnt++;
            done_cyc = cyc;
         end
      end
      cyc++;
   end

   task automatic clear_track();
      q.delete();
      exp_addr = 0; exp_col = 0; loads = 0; done_cnt = 0;
      first_rd = -1; last_rd = -1;
   endtask

   task automatic chk_zero(input string pfx);
      chk({pfx, "_pix_addr"}, int'(pix_addr), 0);
      chk({pfx, "_pix_rd"}, int'(pix_rd), 0);
      chk({pfx, "_row_pix"}, int'(row_pix), 0);
      chk({pfx, "_row_coef_idx"}, int'(row_coef_idx), 0);
      chk({pfx, "_row_en"}, int'(row_en), 0);
      chk({pfx, "_eng_clr"}, int'(eng_clr), 0);
      chk({pfx, "_col_load"}, int'(col_load), 0);
      chk({pfx, "_col_coef_idx"}, int'(col_coef_idx), 0);
      chk({pfx, "_col_en"}, int'(col_en), 0);
      chk({pfx, "_blk_busy"}, int'(blk_busy), 0);
      chk({pfx, "_blk_done"}, int'(blk_done), 0);
      chk({pfx, "_err"}, int'(err), 0);
   endtask

   task automatic run_block(input vec_t v);
      bit got, holding, hold_used, rs_used;
      int hcnt, rs_ph, ij_ph, c_ph, rdn;
      got = 0; holding = 0; hold_used = 0; rs_used = 0;
      hcnt = 0; rs_ph = 0; ij_ph = 0; c_ph = 0; rdn = 0;
      for (int i = 0; i < 64; i++) mem[i] = N'($urandom);
      clear_track();
      blk_start = 1'b1;
      @(negedge clk);
      blk_start = 1'b0;
      chk("eng_clr_pulse", int'(eng_clr), 1);
      chk("busy_on_accept", int'(blk_busy), 1);
      chk("err_cleared_on_start", int'(err), 0);
      @(negedge clk);
      chk("eng_clr_single", int'(eng_clr), 0);
      for (int c = 0; c < 400; c++) begin
         if (blk_done) begin
            got = 1;
            break;
         end
         // backpressure window
         if (holding) begin
            chk("no_rd_during_hold", int'(pix_rd), 0);
            hcnt++;
            if (hcnt == v.hold_len) begin
               hold = 1'b0;
               holding = 0;
            end
         end else if (v.hold_addr >= 0 && !hold_used && pix_rd
                      && int'(pix_addr) == v.hold_addr - 1) begin
            hold = 1'b1;
            holding = 1;
            hold_used = 1;
            hcnt = 0;
         end
         // restart attempt mid-feed
         if (rs_ph == 1) begin
            blk_start = 1'b0;
            chk("restart_no_clr", int'(eng_clr), 0);
            chk("restart_no_err", int'(err), 0);
            rs_ph = 2;
         end else if (v.restart && !rs_used && pix_rd && pix_addr == 6'd10) begin
            blk_start = 1'b1;
            rs_used = 1;
            rs_ph = 1;
         end
         // extra row_done while draining
         if (v.inj) begin
            if (ij_ph == 0 && col_load && col_coef_idx == 3'd7) ij_ph = 1;
            else if (ij_ph == 1) begin
               inj = 1'b1;
               ij_ph = 2;
            end else if (ij_ph == 2) begin
               inj = 1'b0;
               chk("drain_row_done_no_load", int'(col_load), 0);
               chk("drain_row_done_err", int'(err), 1);
               ij_ph = 3;
            end
         end
         // row_done coincident with hold
         if (v.coinc) begin
            if (row_done) rdn++;
            if (c_ph == 0 && rdn == 3) begin
               hold = 1'b1;
               c_ph = 1;
            end else if (c_ph == 1) begin
               chk("coinc_col_load", int'(col_load), 1);
               chk("coinc_col_coef_idx", int'(col_coef_idx), 2);
               c_ph = 2;
            end else if (c_ph == 2) begin
               c_ph = 3;
            end else if (c_ph == 3) begin
               hold = 1'b0;
               c_ph = 4;
            end
         end
         @(negedge clk);
      end
      hold = 1'b0;
      inj = 1'b0;
      blk_start = 1'b0;
      if (!got) begin
         chk("blk_done_timeout", 0, 1);
      end else begin
         chk("busy_at_done", int'(blk_busy), 1);
         chk("col_en_at_done", int'(col_en), 1);
         @(negedge clk);
         chk("blk_done_single", int'(blk_done), 0);
         chk("busy_after_done", int'(blk_busy), 0);
         chk("col_en_after_done", int'(col_en), 0);
         chk("done_count", done_cnt, 1);
         chk("col_load_count", loads, 8);
         chk("reads_issued", exp_addr, 64);
         chk("feed_span", last_rd - first_rd + 1, v.span);
         chk("drain_latency", done_cyc - last_load_cyc, int'(COL_LAT) + 1);
         chk("scoreboard_empty", q.size(), 0);
         chk("err_final", int'(err), int'(v.exp_err));
      end
   endtask

   vec_t vecs [7];

   initial begin
      bit found;
      vecs = '{
         '{hold_addr: -1, hold_len: 0, restart: 1'b0, inj: 1'b0, coinc: 1'b0, span: 64, exp_err: 1'b0},
         '{hold_addr: 20, hold_len: 5, restart: 1'b0, inj: 1'b0, coinc: 1'b0, span: 69, exp_err: 1'b0},
         '{hold_addr: -1, hold_len: 0, restart: 1'b1, inj: 1'b0, coinc: 1'b0, span: 64, exp_err: 1'b0},
         '{hold_addr: -1, hold_len: 0, restart: 1'b0, inj: 1'b1, coinc: 1'b0, span: 64, exp_err: 1'b1},
         '{hold_addr: 63, hold_len: 2, restart: 1'b0, inj: 1'b0, coinc: 1'b0, span: 66, exp_err: 1'b0},
         '{hold_addr: -1, hold_len: 0, restart: 1'b0, inj: 1'b0, coinc: 1'b1, span: 67, exp_err: 1'b0},
         '{hold_addr: -1, hold_len: 0, restart: 1'b0, inj: 1'b0, coinc: 1'b0, span: 64, exp_err: 1'b0}
      };
      reset = 1'b1; blk_start = 1'b0; hold = 1'b0; inj = 1'b0;
      cyc = 0; last_load_cyc = 0; done_cyc = 0;
      clear_track();
      repeat (2) @(negedge clk);
      chk_zero("reset_state");
      reset = 1'b0;
      repeat (2) @(negedge clk);
      chk("idle_busy", int'(blk_busy), 0);

      for (int i = 0; i < 7; i++) begin
         if (i > 0) chk("err_sticky_idle", int'(err), int'(vecs[i-1].exp_err));
         run_block(vecs[i]);
         repeat (2) @(negedge clk);
      end

      // row_done while idle is a protocol error with no column load
      inj = 1'b1;
      @(negedge clk);
      inj = 1'b0;
      chk("idle_row_done_err", int'(err), 1);
      chk("idle_row_done_no_load", int'(col_load), 0);
      repeat (2) @(negedge clk);
      chk("idle_err_sticky", int'(err), 1);
      run_block(vecs[0]);

      // reset in the middle of a block
      repeat (2) @(negedge clk);
      clear_track();
      for (int i = 0; i < 64; i++) mem[i] = N'($urandom);
      blk_start = 1'b1;
      @(negedge clk);
      blk_start = 1'b0;
      found = 0;
      for (int c = 0; c < 200 && !found; c++) begin
         @(negedge clk);
         if (pix_rd && pix_addr == 6'd37) found = 1;
      end
      chk("reach_addr_37", int'(found), 1);
      #2 reset = 1'b1;
      #1 chk_zero("async_reset");
      q.delete();
      repeat (2) @(negedge clk);
      reset = 1'b0;
      repeat (3) @(negedge clk);
      chk("reset_no_blk_done", done_cnt, 0);
      chk("reset_idle_busy", int'(blk_busy), 0);
      run_block(vecs[0]);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
